// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through data cache with one 32-bit word
// per line, an uncached I/O window selected by addr[17:16], and cacheable
// load hit/miss counters. Stores always go to memory; only full-word store
// misses allocate, partial store hits merge into the line.

module dcache_wt #(
    parameter int         BLOCK_NUM_LOG2 = 7,
    parameter int         TAG_MSB        = 17,
    parameter logic [1:0] IO_SEL         = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    input  logic        flush_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int NUM_LINES = 1 << BLOCK_NUM_LOG2;
    localparam int TAG_LSB   = BLOCK_NUM_LOG2 + 2;
    localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state;
    logic                      cacheable_q;   // outstanding read may fill a line
    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_W-1:0]          tag_mem  [NUM_LINES];
    logic [31:0]               data_mem [NUM_LINES];

    logic [BLOCK_NUM_LOG2-1:0] req_idx;
    logic [TAG_W-1:0]          req_tag;
    logic                      req_uncached;
    logic                      req_hit;
    logic [31:0]               merged;
    logic [BLOCK_NUM_LOG2-1:0] fill_idx;
    logic [TAG_W-1:0]          fill_tag;

    logic                      arr_we;
    logic [BLOCK_NUM_LOG2-1:0] arr_idx;
    logic [TAG_W-1:0]          arr_tag;
    logic [31:0]               arr_data;

    assign req_ready_o  = (state == IDLE) && !rst;

    assign req_idx      = req_addr_i[BLOCK_NUM_LOG2+1:2];
    assign req_tag      = req_addr_i[TAG_MSB:TAG_LSB];
    assign req_uncached = (req_addr_i[17:16] == IO_SEL);
    assign req_hit      = !req_uncached && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // A cacheable read keeps its word-aligned address on mem_addr_o, so the
    // fill location is recovered from there rather than from a second copy.
    assign fill_idx     = mem_addr_o[BLOCK_NUM_LOG2+1:2];
    assign fill_tag     = mem_addr_o[TAG_MSB:TAG_LSB];

    // Store data merged byte-wise over the currently cached word.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        merged = data_mem[req_idx];
        for (int b = 0; b < 4; b++) begin
            if (req_wmask_i[b]) begin
                merged[8*b +: 8] = req_wdata_i[8*b +: 8];
            end
        end
    end

    // Select the single line write of this cycle: store hit/allocate or read fill.
    always_comb begin
        arr_we   = 1'b0;
        arr_idx  = req_idx;
        arr_tag  = req_tag;
        arr_data = merged;
        if (!rst && rdy) begin
            if (state == IDLE && req_valid_i && req_we_i && !req_uncached) begin
                if (req_hit) begin
                    arr_we = 1'b1;
                end else if (req_wmask_i == 4'hF) begin
                    arr_we   = 1'b1;
                    arr_data = req_wdata_i;
                end
            end else if (state == MEM_RD && mem_done_i && cacheable_q) begin
                arr_we   = 1'b1;
                arr_idx  = fill_idx;
                arr_tag  = fill_tag;
                arr_data = mem_rdata_i;
            end
        end
    end

    // Valid bits: cleared by reset and flush; flush beats a same-cycle fill.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            valid_q <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (arr_we) begin
                valid_q[arr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; the valid bits alone decide whether
        // their contents mean anything, which keeps them mappable to RAM.
        if (arr_we) begin
            tag_mem[arr_idx]  <= arr_tag;
            data_mem[arr_idx] <= arr_data;
        end
    end

    // Request FSM with registered response, memory request and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cacheable_q  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_wmask_o  <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_we_i) begin
                            state       <= MEM_WR;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= req_addr_i;
                            mem_wdata_o <= req_wdata_i;
                            mem_wmask_o <= req_wmask_i;
                            cacheable_q <= 1'b0;
                        end else if (req_uncached) begin
                            state       <= MEM_RD;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= req_addr_i;
                            mem_wdata_o <= '0;
                            mem_wmask_o <= req_wmask_i;
                            cacheable_q <= 1'b0;
                        end else if (req_hit) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= data_mem[req_idx];
                            hit_cnt_o    <= hit_cnt_o + 32'd1;
                        end else begin
                            state       <= MEM_RD;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                            mem_wdata_o <= '0;
                            mem_wmask_o <= 4'hF;
                            cacheable_q <= 1'b1;
                            miss_cnt_o  <= miss_cnt_o + 32'd1;
                        end
                    end
                end
                MEM_RD: begin
                    if (mem_done_i) begin
                        state        <= RESP;
                        mem_req_o    <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= mem_rdata_i;
                    end
                end
                MEM_WR: begin
                    if (mem_done_i) begin
                        state        <= RESP;
                        mem_req_o    <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= '0;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: self-checking bench for dcache_wt. The bench plays the memory
// controller and keeps a line-level reference model of the cache computed
// from address arithmetic.

module tb_dcache_wt;

    localparam int N     = 128;   // lines for default BLOCK_NUM_LOG2
    localparam int TAGS  = 512;   // tag values for default TAG_MSB

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        req_valid_i, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wmask_i;
    logic        flush_i;
    logic        req_ready_o, resp_valid_o;
    logic [31:0] resp_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model
    bit          mv [N];
    int unsigned mt [N];
    logic [31:0] md [N];
    logic [31:0] exp_hit  = 0;
    logic [31:0] exp_miss = 0;

    // Observations of the last access
    bit          obs_mem, obs_ok;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic [3:0]  obs_wmask;

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .req_valid_i  (req_valid_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wmask_i  (req_wmask_i),
        .flush_i      (flush_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_done_i   (mem_done_i),
        .mem_rdata_i  (mem_rdata_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    function automatic int unsigned f_idx(input logic [31:0] a);
        return (a / 4) % N;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] a);
        return (a / (4 * N)) % TAGS;
    endfunction

    function automatic bit f_io(input logic [31:0] a);
        return ((a / 65536) % 4) == 3;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
    endtask

    // Expected outcome of one access; updates the model state.
    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input logic [31:0] mrdata, input bit fl,
                                output bit e_mem, output logic [31:0] e_addr,
                                output logic [3:0] e_mask, output logic [31:0] e_data);
        int unsigned i, t;
        i = f_idx(addr);
        t = f_tag(addr);
        if (we) begin
            e_mem = 1; e_addr = addr; e_mask = mask; e_data = 0;
            if (!f_io(addr)) begin
                if (mv[i] && mt[i] == t) begin
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) md[i][8*b +: 8] = wdata[8*b +: 8];
                end else if (mask == 4'hF) begin
                    mv[i] = 1; mt[i] = t; md[i] = wdata;
                end
            end
            if (fl) model_clear();
        end else if (f_io(addr)) begin
            e_mem = 1; e_addr = addr; e_mask = mask; e_data = mrdata;
            if (fl) model_clear();
        end else if (mv[i] && mt[i] == t) begin
            e_mem = 0; e_addr = 0; e_mask = 0; e_data = md[i];
            exp_hit = exp_hit + 1;
        end else begin
            e_mem = 1; e_addr = addr - (addr % 4); e_mask = 4'hF; e_data = mrdata;
            exp_miss = exp_miss + 1;
            mv[i] = 1; mt[i] = t; md[i] = mrdata;
            if (fl) model_clear();
        end
    endtask

    // Drive one request and act as the memory controller. Starts and ends just after a negedge.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] mrdata, input int delay, input bit fl);
        int wait_n;
        obs_mem = 0; obs_ok = 0; obs_data = 0;
        obs_we = 0; obs_addr = 0; obs_wdata = 0; obs_wmask = 0;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_before_req: got %b want 1", req_ready_o);
        end
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_wmask_i = mask;
        @(negedge clk);
        if (resp_valid_o !== 1'b1) begin
            wait_n = 0;
            while (mem_req_o !== 1'b1 && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            checks++;
            if (mem_req_o !== 1'b1) begin
                errors++; $display("FAIL mem_req_timeout: addr %h, no mem_req_o and no resp", addr);
                req_valid_i = 0;
                @(negedge clk);
                return;
            end
            obs_mem = 1; obs_we = mem_we_o; obs_addr = mem_addr_o;
            obs_wdata = mem_wdata_o; obs_wmask = mem_wmask_o;
            repeat (delay) begin
                @(negedge clk);
                checks++;
                if (mem_req_o !== 1'b1 || mem_we_o !== obs_we || mem_addr_o !== obs_addr ||
                    mem_wdata_o !== obs_wdata || mem_wmask_o !== obs_wmask) begin
                    errors++;
                    $display("FAIL mem_hold: req %b addr %h we %b, expected held req 1 addr %h we %b",
                             mem_req_o, mem_addr_o, mem_we_o, obs_addr, obs_we);
                end
            end
            mem_done_i = 1; mem_rdata_i = mrdata; flush_i = fl;
            @(negedge clk);
            mem_done_i = 0; mem_rdata_i = 0; flush_i = 0;
            checks++;
            if (mem_req_o !== 1'b0) begin
                errors++; $display("FAIL mem_req_drop: got %b want 0 after mem_done_i", mem_req_o);
            end
        end
        obs_ok = (resp_valid_o === 1'b1);
        obs_data = resp_data_o;
        req_valid_i = 0;
        @(negedge clk);
        checks++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL resp_pulse: resp_valid %b ready %b, want 0 and 1", resp_valid_o, req_ready_o);
        end
    endtask

    // One access compared against the model.
    task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [31:0] mrdata, input int delay, input bit fl);
        bit          e_mem;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_mask;
        model_access(we, addr, wdata, mask, mrdata, fl, e_mem, e_addr, e_mask, e_data);
        access(we, addr, wdata, mask, mrdata, delay, fl);
        checks++;
        if (obs_mem !== e_mem) begin
            errors++; $display("FAIL mem_used: addr %h we %b got %b want %b", addr, we, obs_mem, e_mem);
        end
        if (e_mem && obs_mem) begin
            checks++;
            if (obs_addr !== e_addr || obs_we !== we || obs_wmask !== e_mask || (we && obs_wdata !== wdata)) begin
                errors++;
                $display("FAIL mem_fields: got addr %h we %b mask %h wdata %h want addr %h we %b mask %h wdata %h",
                         obs_addr, obs_we, obs_wmask, obs_wdata, e_addr, we, e_mask, wdata);
            end
        end
        checks++;
        if (!obs_ok) begin
            errors++; $display("FAIL resp_valid: addr %h got no response pulse, want one", addr);
        end
        checks++;
        if (obs_data !== e_data) begin
            errors++; $display("FAIL resp_data: addr %h got %h want %h", addr, obs_data, e_data);
        end
    endtask

    task automatic idle_flush();
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        model_clear();
    endtask

    task automatic test_counters(input string name);
        checks++;
        if (hit_cnt_o !== exp_hit || miss_cnt_o !== exp_miss) begin
            errors++;
            $display("FAIL %s_counters: hit %0d miss %0d want hit %0d miss %0d",
                     name, hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
        end
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
        req_wmask_i = 0; flush_i = 0; mem_done_i = 0; mem_rdata_i = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready_o !== 0 || resp_valid_o !== 0 || resp_data_o !== 0 || mem_req_o !== 0 ||
            mem_we_o !== 0 || mem_addr_o !== 0 || mem_wdata_o !== 0 || mem_wmask_o !== 0 ||
            hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ready %b resp %b data %h mreq %b addr %h hit %0d miss %0d, want all 0",
                     req_ready_o, resp_valid_o, resp_data_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o);
        end
        rst = 0;
        model_clear();
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1 after reset release", req_ready_o);
        end
    endtask

    task automatic test_load_miss_hit();
        xact(0, 32'h0000_0100, 0, 4'hF, 32'hDEAD_BEEF, 3, 0);
        checks++;
        if (obs_data !== 32'hDEAD_BEEF || miss_cnt_o !== 32'd1) begin
            errors++; $display("FAIL first_miss: data %h miss %0d want DEADBEEF and 1", obs_data, miss_cnt_o);
        end
        xact(0, 32'h0000_0100, 0, 4'hF, 32'h1234_5678, 1, 0);
        checks++;
        if (obs_data !== 32'hDEAD_BEEF || hit_cnt_o !== 32'd1 || obs_mem !== 1'b0) begin
            errors++;
            $display("FAIL first_hit: data %h hit %0d mem %b want DEADBEEF 1 0", obs_data, hit_cnt_o, obs_mem);
        end
    endtask

    task automatic test_store_merge();
        xact(1, 32'h0000_0100, 32'h0000_00AA, 4'b0001, 0, 2, 0);
        xact(0, 32'h0000_0100, 0, 4'hF, 32'h0BAD_0BAD, 1, 0);
        checks++;
        if (obs_data !== 32'hDEAD_BEAA || obs_mem !== 1'b0) begin
            errors++; $display("FAIL store_merge: data %h mem %b want DEADBEAA 0", obs_data, obs_mem);
        end
        test_counters("store_merge");
    endtask

    task automatic test_conflict();
        xact(0, 32'h0000_0300, 0, 4'hF, 32'h3333_3333, 0, 0);
        xact(0, 32'h0000_0100, 0, 4'hF, 32'h1111_1111, 2, 0);
        checks++;
        if (obs_mem !== 1'b1 || obs_data !== 32'h1111_1111) begin
            errors++; $display("FAIL conflict_reload: mem %b data %h want 1 11111111", obs_mem, obs_data);
        end
        test_counters("conflict");
    endtask

    task automatic test_store_alloc();
        xact(1, 32'h0000_0704, 32'hCAFE_F00D, 4'hF, 0, 1, 0);
        xact(0, 32'h0000_0704, 0, 4'hF, 32'h5555_5555, 1, 0);
        checks++;
        if (obs_mem !== 1'b0 || obs_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL store_alloc: mem %b data %h want 0 CAFEF00D", obs_mem, obs_data);
        end
        xact(1, 32'h0000_0908, 32'h0000_7700, 4'b0010, 0, 0, 0);
        xact(0, 32'h0000_0908, 0, 4'hF, 32'h6666_6666, 0, 0);
        test_counters("store_alloc");
    endtask

    task automatic test_uncached();
        logic [31:0] h0, m0;
        h0 = hit_cnt_o; m0 = miss_cnt_o;
        xact(0, 32'h0003_0000, 0, 4'b0001, 32'h0000_00A1, 1, 0);
        xact(0, 32'h0003_0000, 0, 4'b0001, 32'h0000_00B2, 1, 0);
        checks++;
        if (obs_mem !== 1'b1 || obs_data !== 32'h0000_00B2 || hit_cnt_o !== h0 || miss_cnt_o !== m0) begin
            errors++;
            $display("FAIL uncached: mem %b data %h hit %0d miss %0d want 1 000000B2 %0d %0d",
                     obs_mem, obs_data, hit_cnt_o, miss_cnt_o, h0, m0);
        end
    endtask

    task automatic test_flush();
        xact(0, 32'h0000_0500, 0, 4'hF, 32'h5005_5005, 2, 1);
        xact(0, 32'h0000_0500, 0, 4'hF, 32'h5115_5115, 0, 0);
        checks++;
        if (obs_mem !== 1'b1 || obs_data !== 32'h5115_5115) begin
            errors++; $display("FAIL flush_vs_fill: mem %b data %h want 1 51155115", obs_mem, obs_data);
        end
        idle_flush();
        xact(0, 32'h0000_0500, 0, 4'hF, 32'h5225_5225, 0, 0);
        checks++;
        if (obs_mem !== 1'b1) begin
            errors++; $display("FAIL idle_flush: mem %b want 1", obs_mem);
        end
        test_counters("flush");
    endtask

    task automatic test_rdy_freeze();
        bit          e_mem;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_mask;
        // request held while rdy is low in IDLE is not sampled
        rdy = 0; req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h0000_0B00; req_wmask_i = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            errors++; $display("FAIL rdy_idle: mem_req %b resp %b want 0 0", mem_req_o, resp_valid_o);
        end
        rdy = 1; req_valid_i = 0;
        model_access(0, 32'h0000_0B00, 0, 4'hF, 32'hB00B_B00B, 0, e_mem, e_addr, e_mask, e_data);
        req_valid_i = 1;
        @(negedge clk);
        rdy = 0; mem_done_i = 1; mem_rdata_i = 32'hB00B_B00B;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || resp_valid_o !== 1'b0 || miss_cnt_o !== exp_miss) begin
            errors++;
            $display("FAIL rdy_freeze: mem_req %b resp %b miss %0d want 1 0 %0d",
                     mem_req_o, resp_valid_o, miss_cnt_o, exp_miss);
        end
        rdy = 1;
        @(negedge clk);
        mem_done_i = 0; mem_rdata_i = 0;
        checks++;
        if (resp_valid_o !== 1'b1 || resp_data_o !== e_data || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rdy_resume: resp %b data %h mem_req %b want 1 %h 0",
                     resp_valid_o, resp_data_o, mem_req_o, e_data);
        end
        req_valid_i = 0;
        @(negedge clk);
        xact(0, 32'h0000_0B00, 0, 4'hF, 32'h0, 0, 0);
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h0000_0D00; req_wmask_i = 4'hF;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: mem_req %b want 1", mem_req_o);
        end
        rst = 1; req_valid_i = 0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 0 || resp_valid_o !== 0 || hit_cnt_o !== 0 || miss_cnt_o !== 0 ||
            mem_addr_o !== 0 || req_ready_o !== 0) begin
            errors++;
            $display("FAIL reset_mid: mem_req %b resp %b hit %0d miss %0d addr %h ready %b want all 0",
                     mem_req_o, resp_valid_o, hit_cnt_o, miss_cnt_o, mem_addr_o, req_ready_o);
        end
        rst = 0;
        model_clear(); exp_hit = 0; exp_miss = 0;
        mem_done_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (resp_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++; $display("FAIL reset_no_resp: resp %b mem_req %b want 0 0", resp_valid_o, mem_req_o);
            end
        end
        mem_done_i = 0; mem_rdata_i = 0;
        xact(0, 32'h0000_0100, 0, 4'hF, 32'h0101_0101, 1, 0);
        xact(0, 32'h0000_0D00, 0, 4'hF, 32'h0D0D_0D0D, 0, 0);
        test_counters("reset_mid");
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, mrdata;
        logic [3:0]  mask;
        bit          we, fl;
        for (int n = 0; n < 300; n++) begin
            addr = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) addr = addr | 32'h0003_0000;
            else if ($urandom_range(0, 3) == 0) addr = addr | 32'h0001_0000;
            we     = ($urandom_range(0, 2) == 0);
            wdata  = $urandom;
            mrdata = $urandom;
            mask   = 4'($urandom_range(1, 15));
            if (we && $urandom_range(0, 2) == 0) mask = 4'hF;
            fl     = ($urandom_range(0, 9) == 0);
            xact(we, addr, wdata, mask, mrdata, $urandom_range(0, 3), fl);
            if ($urandom_range(0, 19) == 0) idle_flush();
        end
        test_counters("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_miss_hit();
        test_store_merge();
        test_conflict();
        test_store_alloc();
        test_uncached();
        test_flush();
        test_rdy_freeze();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have parameter BLOCK_NUM_LOG2, default 7, log2 of the line count (one 32-bit word per line).
REQ-002 SHALL have parameter TAG_MSB, default 17, the highest address bit covered by the tag.
REQ-003 SHALL have parameter IO_SEL, default 2'b11; a request with addr[17:16]==IO_SEL is uncached.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rdy, input, 1, global ready; while low, all state holds.
REQ-007 SHALL have port req_valid_i, input, 1, access request, held high until resp_valid_o.
REQ-008 SHALL have port req_we_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr_i, input, 32, byte address.
REQ-010 SHALL have port req_wdata_i, input, 32, store data, already lane-aligned.
REQ-011 SHALL have port req_wmask_i, input, 4, byte enables for stores and uncached loads.
REQ-012 SHALL have port flush_i, input, 1, invalidates all lines.
REQ-013 SHALL have port req_ready_o, output, 1, high when the FSM is in IDLE and rst is low.
REQ-014 SHALL have port resp_valid_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port resp_data_o, output, 32, load data; zero for stores.
REQ-016 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, 32), mem_wdata_o (output, 32), mem_wmask_o (output, 4), forming the memory-controller request.
REQ-017 SHALL have ports mem_done_i (input, 1) and mem_rdata_i (input, 32), forming the memory-controller completion.
REQ-018 SHALL have ports hit_cnt_o (output, 32) and miss_cnt_o (output, 32), cacheable-load hit and miss counters.

Function
REQ-019 SHALL use index = addr[BLOCK_NUM_LOG2+1:2] and tag = addr[TAG_MSB:BLOCK_NUM_LOG2+2]; each line holds a valid bit, a tag and 32 bits of data.
REQ-020 SHALL implement the FSM states IDLE, MEM_RD, MEM_WR and RESP.
REQ-021 SHALL sample a request only in IDLE with rdy high; it SHALL ignore req_valid_i in all other states.
REQ-022 SHALL handle a cacheable load hit (valid and tag match) sampled at cycle T by going IDLE->RESP, with resp_valid_o high at T+1, resp_data_o = line data, and hit_cnt_o incremented.
REQ-023 SHALL handle a cacheable load miss by going IDLE->MEM_RD and incrementing miss_cnt_o, with mem_addr_o = {addr[31:2],2'b00} and mem_wmask_o = 4'hF.
REQ-024 SHALL handle an uncached load by going IDLE->MEM_RD with the full address and req_wmask_i; it SHALL not fill the cache and SHALL not change either counter.
REQ-025 SHALL, in MEM_RD and MEM_WR, hold mem_req_o high with constant request fields until mem_done_i is sampled high at cycle D.
REQ-026 SHALL drop mem_req_o in cycle D+1.
REQ-027 SHALL, on mem_done_i in MEM_RD, register mem_rdata_i and go to RESP.
REQ-028 SHALL, for a cacheable mem_done_i in MEM_RD, write the line (valid=1, tag, data).
REQ-029 SHALL, in either case of REQ-027/028, pulse resp_valid_o at D+1.
REQ-030 SHALL treat stores as write-through with no write-allocate on a partial mask; a store goes IDLE->MEM_WR with mem_we_o=1 and the address, data and mask passed unchanged.
REQ-031 SHALL, on a cacheable store hit, merge the enabled bytes into the line at acceptance cycle T+1.
REQ-032 SHALL, on a cacheable store miss with mask 4'hF, allocate the line at T+1.
REQ-033 SHALL leave the cache unchanged on a cacheable store miss with any other mask.
REQ-034 SHALL, on mem_done_i in MEM_WR, go to RESP with resp_valid_o at D+1 and resp_data_o = 0.
REQ-035 SHALL always return from RESP to IDLE after one cycle.
REQ-036 SHALL, on flush_i sampled high, clear every valid bit on that edge; in the same cycle, flush wins over a fill or allocate, leaving the line invalid.
REQ-037 SHALL not abort an in-flight memory access because of flush_i.
REQ-038 SHALL, with rdy low, freeze the FSM, arrays, counters and outputs, and not sample mem_done_i.
REQ-039 SHALL wrap both counters modulo 2^32.
REQ-040 SHALL drive mem_req_o low in IDLE and RESP.

Reset
REQ-041 SHALL, on rst high at a rising edge, go to IDLE, clear all valid bits and both counters, and drive resp_valid_o=0, resp_data_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0 and mem_wmask_o=0.
REQ-042 SHALL keep rst priority over rdy, flush_i and mem_done_i.
REQ-043 SHALL, when reset arrives mid-access, abandon the access, perform no fill and issue no response.
REQ-044 SHALL leave the tag and data arrays uninitialised by reset.

Verification
REQ-045 SHALL cover: load 0x00000100 miss, mem_done_i after 3 cycles with rdata 0xDEADBEEF -> resp 0xDEADBEEF, miss_cnt=1; repeat load -> resp at T+1 0xDEADBEEF, hit_cnt=1, mem_req_o stays low.
REQ-046 SHALL cover: store 0x00000100 data 0x000000AA mask 4'b0001 after the fill above -> mem write issued; a following load hits with 0xDEADBEAA.
REQ-047 SHALL cover: load 0x00000100, then load 0x00000300 (same index for the default parameters, different tag) -> second load misses and refills; reload 0x00000100 misses again.
REQ-048 SHALL cover: load 0x00030000 mask 4'b0001 (uncached) twice -> two memory reads, counters unchanged, no line written.
REQ-049 SHALL cover: flush_i asserted in the same cycle as mem_done_i of a cacheable load -> resp delivered with the data, and the next load to that address misses.
REQ-050 SHALL cover: rst asserted in MEM_RD -> mem_req_o=0 next cycle, no resp_valid_o, counters=0, and a subsequent load to any address misses.
